// File: rtl/id_ex_stage.sv
// ID/EX pipeline register and operand-select stage feeding the 64-bit ALU.
// Holds the decoded instruction for one cycle, generates the ALU control code
// at capture time, and forwards EX/MEM and MEM/WB results into the operands.
module id_ex_stage #(
    parameter int XLEN   = 64,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [1:0]        id_alu_op,
    input  logic [2:0]        id_funct3,
    input  logic              id_funct7_5,
    input  logic              id_alu_src,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              id_branch,
    input  logic              exm_reg_write,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic [XLEN-1:0]   exm_result,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic              ex_valid,
    output logic [XLEN-1:0]   alu_a,
    output logic [XLEN-1:0]   alu_b,
    output logic [3:0]        alu_control_signal,
    output logic [XLEN-1:0]   ex_store_data,
    output logic [XLEN-1:0]   ex_pc,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic              ex_branch
);

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    logic              valid_q, valid_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   rs1_data_q, rs1_data_d;
    logic [XLEN-1:0]   rs2_data_q, rs2_data_d;
    logic [XLEN-1:0]   imm_q, imm_d;
    logic [REG_AW-1:0] rs1_q, rs1_d;
    logic [REG_AW-1:0] rs2_q, rs2_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic              alu_src_q, alu_src_d;
    logic              reg_write_q, reg_write_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic              mem_to_reg_q, mem_to_reg_d;
    logic              branch_q, branch_d;
    logic [3:0]        alu_ctrl_q, alu_ctrl_d;

    logic [3:0]        alu_ctrl_dec;
    logic              op_supported;
    logic [XLEN-1:0]   fwd_a;
    logic [XLEN-1:0]   fwd_b;

    // Decode ALU control from the ID fields; unsupported funct3 becomes a non-writing add.
    always_comb begin
        alu_ctrl_dec = ALU_ADD;
        op_supported = 1'b1;
        if (id_alu_op == 2'b00) begin
            alu_ctrl_dec = ALU_ADD;
        end else if (id_alu_op == 2'b01) begin
            alu_ctrl_dec = ALU_SUB;
        end else begin
            case (id_funct3)
                3'b000:  alu_ctrl_dec = (id_alu_op == 2'b10 && id_funct7_5) ? ALU_SUB : ALU_ADD;
                3'b111:  alu_ctrl_dec = ALU_AND;
                3'b110:  alu_ctrl_dec = ALU_OR;
                3'b100:  alu_ctrl_dec = ALU_XOR;
                3'b001:  alu_ctrl_dec = ALU_SLL;
                default: begin
                    alu_ctrl_dec = ALU_ADD;
                    op_supported = 1'b0;
                end
            endcase
        end
    end

    // Next-state: flush bubbles the control bits, stall holds, otherwise capture ID.
    always_comb begin
        valid_d      = valid_q;
        pc_d         = pc_q;
        rs1_data_d   = rs1_data_q;
        rs2_data_d   = rs2_data_q;
        imm_d        = imm_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        rd_d         = rd_q;
        alu_src_d    = alu_src_q;
        reg_write_d  = reg_write_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_to_reg_d = mem_to_reg_q;
        branch_d     = branch_q;
        alu_ctrl_d   = alu_ctrl_q;
        if (flush) begin
            valid_d      = 1'b0;
            reg_write_d  = 1'b0;
            mem_read_d   = 1'b0;
            mem_write_d  = 1'b0;
            mem_to_reg_d = 1'b0;
            branch_d     = 1'b0;
        end else if (!stall) begin
            valid_d      = id_valid;
            pc_d         = id_pc;
            rs1_data_d   = id_rs1_data;
            rs2_data_d   = id_rs2_data;
            imm_d        = id_imm;
            rs1_d        = id_rs1;
            rs2_d        = id_rs2;
            rd_d         = id_rd;
            alu_src_d    = id_alu_src;
            reg_write_d  = id_reg_write & id_valid & op_supported;
            mem_read_d   = id_mem_read & id_valid;
            mem_write_d  = id_mem_write & id_valid;
            mem_to_reg_d = id_mem_to_reg & id_valid;
            branch_d     = id_branch & id_valid;
            alu_ctrl_d   = alu_ctrl_dec;
        end
    end

    // Stage registers with synchronous reset to an empty slot decoding as add.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q      <= 1'b0;
            pc_q         <= '0;
            rs1_data_q   <= '0;
            rs2_data_q   <= '0;
            imm_q        <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rd_q         <= '0;
            alu_src_q    <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            branch_q     <= 1'b0;
            alu_ctrl_q   <= ALU_ADD;
        end else begin
            valid_q      <= valid_d;
            pc_q         <= pc_d;
            rs1_data_q   <= rs1_data_d;
            rs2_data_q   <= rs2_data_d;
            imm_q        <= imm_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            rd_q         <= rd_d;
            alu_src_q    <= alu_src_d;
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            branch_q     <= branch_d;
            alu_ctrl_q   <= alu_ctrl_d;
        end
    end

    // Operand forwarding: EX/MEM wins over MEM/WB, x0 is never forwarded.
    always_comb begin
        fwd_a = rs1_data_q;
        fwd_b = rs2_data_q;
        if (exm_reg_write && exm_rd != '0 && exm_rd == rs1_q) begin
            fwd_a = exm_result;
        end else if (wb_reg_write && wb_rd != '0 && wb_rd == rs1_q) begin
            fwd_a = wb_data;
        end
        if (exm_reg_write && exm_rd != '0 && exm_rd == rs2_q) begin
            fwd_b = exm_result;
        end else if (wb_reg_write && wb_rd != '0 && wb_rd == rs2_q) begin
            fwd_b = wb_data;
        end
    end

    assign alu_a              = fwd_a;
    assign alu_b              = alu_src_q ? imm_q : fwd_b;
    assign ex_store_data      = fwd_b;
    assign alu_control_signal = alu_ctrl_q;
    assign ex_valid           = valid_q;
    assign ex_pc              = pc_q;
    assign ex_rd              = rd_q;
    assign ex_reg_write       = reg_write_q;
    assign ex_mem_read        = mem_read_q;
    assign ex_mem_write       = mem_write_q;
    assign ex_mem_to_reg      = mem_to_reg_q;
    assign ex_branch          = branch_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: each edge's expected EX view is pushed
// when the inputs are driven and popped for comparison just after the edge.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush;
    logic        id_valid;
    logic [63:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [1:0]  id_alu_op;
    logic [2:0]  id_funct3;
    logic        id_funct7_5, id_alu_src;
    logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch;
    logic        exm_reg_write;
    logic [4:0]  exm_rd;
    logic [63:0] exm_result;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        ex_valid;
    logic [63:0] alu_a, alu_b, ex_store_data, ex_pc;
    logic [3:0]  alu_control_signal;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
        .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_op(id_alu_op),
        .id_funct3(id_funct3), .id_funct7_5(id_funct7_5), .id_alu_src(id_alu_src),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .id_branch(id_branch), .exm_reg_write(exm_reg_write), .exm_rd(exm_rd),
        .exm_result(exm_result), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
        .wb_data(wb_data), .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b),
        .alu_control_signal(alu_control_signal), .ex_store_data(ex_store_data),
        .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int txn   = 0;

    typedef struct {
        logic        valid;
        logic [63:0] a, b, sd, pc;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic        rw, mr, mw, m2r, br;
    } exp_t;
    exp_t sbq[$];

    // Reference copy of the stage contents
    logic        m_valid, m_src, m_rw, m_mr, m_mw, m_m2r, m_br;
    logic [63:0] m_pc, m_rs1d, m_rs2d, m_imm;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [3:0]  m_ctrl;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // ALU code expected for an instruction; sup=0 marks an unsupported op.
    function automatic logic [4:0] ref_ctl(input logic [1:0] op, input logic [2:0] f3, input logic f75);
        logic [3:0] c;
        logic       sup;
        sup = 1'b1;
        if (op == 2'b00)      c = 4'b0010;
        else if (op == 2'b01) c = 4'b0110;
        else if (f3 == 3'b000) c = (op == 2'b10 && f75) ? 4'b0110 : 4'b0010;
        else if (f3 == 3'b111) c = 4'b0000;
        else if (f3 == 3'b110) c = 4'b0001;
        else if (f3 == 3'b100) c = 4'b0100;
        else if (f3 == 3'b001) c = 4'b0011;
        else begin c = 4'b0010; sup = 1'b0; end
        return {sup, c};
    endfunction

    function automatic logic [63:0] ref_fwd(input logic [4:0] r, input logic [63:0] regval);
        if (r == 5'd0) return regval;
        if (exm_reg_write && exm_rd == r) return exm_result;
        if (wb_reg_write && wb_rd == r) return wb_data;
        return regval;
    endfunction

    // Advance the reference model across one edge, push the expectation,
    // then clock the DUT and compare against the popped entry.
    task automatic step();
        exp_t e, g;
        logic [4:0] cs;
        if (reset) begin
            m_valid = 0; m_src = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_m2r = 0; m_br = 0;
            m_pc = 0; m_rs1d = 0; m_rs2d = 0; m_imm = 0;
            m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_ctrl = 4'b0010;
        end else if (flush) begin
            m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_m2r = 0; m_br = 0;
        end else if (!stall) begin
            cs = ref_ctl(id_alu_op, id_funct3, id_funct7_5);
            m_valid = id_valid; m_pc = id_pc; m_rs1d = id_rs1_data; m_rs2d = id_rs2_data;
            m_imm = id_imm; m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd; m_src = id_alu_src;
            m_ctrl = cs[3:0];
            m_rw  = id_valid && id_reg_write && cs[4];
            m_mr  = id_valid && id_mem_read;
            m_mw  = id_valid && id_mem_write;
            m_m2r = id_valid && id_mem_to_reg;
            m_br  = id_valid && id_branch;
        end
        e.valid = m_valid; e.pc = m_pc; e.ctrl = m_ctrl; e.rd = m_rd;
        e.rw = m_rw; e.mr = m_mr; e.mw = m_mw; e.m2r = m_m2r; e.br = m_br;
        e.a  = ref_fwd(m_rs1, m_rs1d);
        e.sd = ref_fwd(m_rs2, m_rs2d);
        e.b  = m_src ? m_imm : e.sd;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        g = sbq.pop_front();
        txn++;
        $display("txn %0d: rst=%0b stl=%0b fl=%0b a=%0h b=%0h ctrl=%0h v=%0b rw=%0b",
                 txn, reset, stall, flush, alu_a, alu_b, alu_control_signal, ex_valid, ex_reg_write);
        check_val("ex_valid",  ex_valid,           g.valid);
        check_val("alu_a",     alu_a,              g.a);
        check_val("alu_b",     alu_b,              g.b);
        check_val("store",     ex_store_data,      g.sd);
        check_val("alu_ctrl",  alu_control_signal, g.ctrl);
        check_val("ex_pc",     ex_pc,              g.pc);
        check_val("ex_rd",     ex_rd,              g.rd);
        check_val("reg_write", ex_reg_write,       g.rw);
        check_val("mem_read",  ex_mem_read,        g.mr);
        check_val("mem_write", ex_mem_write,       g.mw);
        check_val("mem_to_reg", ex_mem_to_reg,     g.m2r);
        check_val("branch",    ex_branch,          g.br);
    endtask

    task automatic set_instr(input logic [1:0] op, input logic [2:0] f3, input logic f75,
                             input logic src, input logic [4:0] r1, input logic [4:0] r2,
                             input logic [4:0] rd, input logic [63:0] d1, input logic [63:0] d2,
                             input logic [63:0] imm);
        id_valid = 1; id_alu_op = op; id_funct3 = f3; id_funct7_5 = f75; id_alu_src = src;
        id_rs1 = r1; id_rs2 = r2; id_rd = rd; id_rs1_data = d1; id_rs2_data = d2; id_imm = imm;
        id_pc = id_pc + 64'd4;
        id_reg_write = 1; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0; id_branch = 0;
    endtask

    initial begin
        reset = 1; stall = 0; flush = 0;
        id_valid = 0; id_pc = 64'h1000; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_alu_op = 0; id_funct3 = 0; id_funct7_5 = 0;
        id_alu_src = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
        id_mem_to_reg = 0; id_branch = 0;
        exm_reg_write = 0; exm_rd = 0; exm_result = 0;
        wb_reg_write = 0; wb_rd = 0; wb_data = 0;
        @(negedge clk);

        // 1. reset for two cycles
        step(); step();
        check_val("rst_ctrl", alu_control_signal, 64'h2);
        check_val("rst_a", alu_a, 64'h0);
        reset = 0;

        // 2. R-type sub
        set_instr(2'b10, 3'b000, 1'b1, 1'b0, 5'd1, 5'd2, 5'd3, 64'd10, 64'd3, 64'd0);
        step();
        check_val("sub_ctrl", alu_control_signal, 64'h6);
        check_val("sub_a", alu_a, 64'd10);
        check_val("sub_b", alu_b, 64'd3);

        // 3. forwarding priority on rs1=5
        set_instr(2'b10, 3'b111, 1'b0, 1'b0, 5'd5, 5'd6, 5'd7, 64'h11, 64'h22, 64'd0);
        exm_reg_write = 1; exm_rd = 5; exm_result = 64'h55;
        wb_reg_write = 1; wb_rd = 5; wb_data = 64'h99;
        step();
        check_val("fwd_exm", alu_a, 64'h55);
        stall = 1; exm_reg_write = 0;
        step();
        check_val("fwd_wb", alu_a, 64'h99);
        stall = 0;
        set_instr(2'b10, 3'b110, 1'b0, 1'b0, 5'd0, 5'd0, 5'd7, 64'd0, 64'd0, 64'd0);
        exm_reg_write = 1; exm_rd = 0; wb_rd = 0;
        step();
        check_val("fwd_x0", alu_a, 64'h0);
        exm_reg_write = 0; wb_reg_write = 0;

        // 4. stall for three cycles while ID changes, then stall+flush
        set_instr(2'b10, 3'b100, 1'b0, 1'b0, 5'd8, 5'd9, 5'd10, 64'hA, 64'hB, 64'd0);
        step();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            set_instr(2'b01, 3'b001, 1'b1, 1'b1, 5'd11, 5'd12, 5'd13,
                      64'(i + 100), 64'(i + 200), 64'(i + 300));
            step();
        end
        check_val("stall_a", alu_a, 64'hA);
        flush = 1;
        step();
        check_val("flush_v", ex_valid, 64'h0);
        check_val("flush_rw", ex_reg_write, 64'h0);
        flush = 0; stall = 0;

        // 5. addi with negative imm, then sd with rs2 from MEM/WB
        set_instr(2'b11, 3'b000, 1'b1, 1'b1, 5'd1, 5'd2, 5'd4, 64'd8, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC);
        step();
        check_val("addi_b", alu_b, 64'hFFFF_FFFF_FFFF_FFFC);
        check_val("addi_ctrl", alu_control_signal, 64'h2);
        set_instr(2'b00, 3'b011, 1'b0, 1'b1, 5'd1, 5'd7, 5'd0, 64'h200, 64'h1, 64'd16);
        id_reg_write = 0; id_mem_write = 1;
        wb_reg_write = 1; wb_rd = 7; wb_data = 64'hABCD;
        exm_reg_write = 1; exm_rd = 3; exm_result = 64'h77;
        step();
        check_val("sd_store", ex_store_data, 64'hABCD);
        check_val("sd_mw", ex_mem_write, 64'h1);
        exm_reg_write = 0; wb_reg_write = 0;

        // 6. unsupported funct3, then invalid slot with mem_write
        set_instr(2'b10, 3'b010, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 64'd1, 64'd2, 64'd0);
        step();
        check_val("slt_rw", ex_reg_write, 64'h0);
        check_val("slt_ctrl", alu_control_signal, 64'h2);
        set_instr(2'b00, 3'b011, 1'b0, 1'b1, 5'd1, 5'd2, 5'd0, 64'd1, 64'd2, 64'd8);
        id_valid = 0; id_mem_write = 1;
        step();
        check_val("inv_mw", ex_mem_write, 64'h0);

        // Random mix with colliding register indices
        for (int i = 0; i < 60; i++) begin
            set_instr(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      5'($urandom_range(0, 31)), {$urandom, $urandom}, {$urandom, $urandom},
                      {$urandom, $urandom});
            id_valid = 1'($urandom_range(0, 3) != 0);
            id_mem_read = 1'($urandom_range(0, 1)); id_mem_write = 1'($urandom_range(0, 1));
            id_mem_to_reg = 1'($urandom_range(0, 1)); id_branch = 1'($urandom_range(0, 1));
            exm_reg_write = 1'($urandom_range(0, 1)); exm_rd = 5'($urandom_range(0, 3));
            exm_result = {$urandom, $urandom};
            wb_reg_write = 1'($urandom_range(0, 1)); wb_rd = 5'($urandom_range(0, 3));
            wb_data = {$urandom, $urandom};
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 6) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
